// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Load/store stage behind the ALU. It accepts one memory operation at a time
//   from the single-cycle core and stalls the core while the operation is in
//   flight. It talks to a variable-latency data RAM over a mem_req/mem_ack
//   handshake and returns the aligned, sign- or zero-extended load value.
//   Misaligned accesses, the illegal size code and a bus timeout are reported
//   through rsp_err.
//
// Parameters
//   TIMEOUT  maximum number of cycles mem_req stays high without an ack
//            (0 disables the timeout)
//   CNT_W    width of the timeout counter; must be able to hold TIMEOUT
//
// Ports
//   clk, rstn                  clock and synchronous active-low reset
//   req_valid/req_ready        core request handshake (ready only in IDLE)
//   req_we, req_size,          operation: store flag, size (00 byte,
//   req_unsigned               01 half, 10 word), zero-extend flag
//   req_addr, req_wdata        effective address and store data (rt)
//   rsp_valid, rsp_rdata,      one-cycle completion pulse, extended load
//   rsp_err                    data, error flag
//   stall                      req_valid & ~rsp_valid, freezes the PC
//   mem_req, mem_we, mem_addr, RAM request, word address, byte enables and
//   mem_be, mem_wdata          lane-replicated write data
//   mem_ack, mem_rdata         RAM completion and read word
module mem_access_unit #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, WAIT_ACK, RESP} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             lat_we;
  logic             lat_unsigned;
  logic [1:0]       lat_size;
  logic [1:0]       lat_off;
  logic             bad_req;
  logic             timeout_hit;

  function automatic logic [3:0] calc_be(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   calc_be = 4'b0001 << off;
      2'b01:   calc_be = off[1] ? 4'b1100 : 4'b0011;
      default: calc_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] calc_wdata(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      2'b00:   calc_wdata = {4{wd[7:0]}};
      2'b01:   calc_wdata = {2{wd[15:0]}};
      default: calc_wdata = wd;
    endcase
  endfunction

  // Bring the addressed lane down to bit 0, then extend to 32 bits.
  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] off,
                                               input logic [1:0] size, input logic uns);
    logic [31:0]        sh;
    logic signed [7:0]  b8;
    logic signed [15:0] h16;
    sh  = word >> {off, 3'b000};
    b8  = sh[7:0];
    h16 = sh[15:0];
    case (size)
      2'b00:   load_extract = uns ? {24'd0, sh[7:0]}  : 32'(b8);
      2'b01:   load_extract = uns ? {16'd0, sh[15:0]} : 32'(h16);
      default: load_extract = sh;
    endcase
  endfunction

  assign bad_req = (req_size == 2'b11) ||
                   ((req_size == 2'b01) && req_addr[0]) ||
                   ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));

  assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));

  assign stall = req_valid & ~rsp_valid;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state        <= IDLE;
      cnt          <= '0;
      lat_we       <= 1'b0;
      lat_unsigned <= 1'b0;
      lat_size     <= 2'b00;
      lat_off      <= 2'b00;
      req_ready    <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      rsp_err      <= 1'b0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_be       <= '0;
      mem_wdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            lat_we       <= req_we;
            lat_unsigned <= req_unsigned;
            lat_size     <= req_size;
            lat_off      <= req_addr[1:0];
            req_ready    <= 1'b0;
            if (bad_req) begin
              // Rejected before the RAM ever sees it.
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              state     <= WAIT_ACK;
              cnt       <= '0;
              mem_req   <= 1'b1;
              mem_we    <= req_we;
              mem_addr  <= {req_addr[31:2], 2'b00};
              mem_be    <= calc_be(req_size, req_addr[1:0]);
              mem_wdata <= calc_wdata(req_size, req_wdata);
            end
          end
        end
        WAIT_ACK: begin
          if (mem_ack) begin
            state     <= RESP;
            cnt       <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= lat_we ? 32'd0 : load_extract(mem_rdata, lat_off, lat_size, lat_unsigned);
          end else if (timeout_hit) begin
            state     <= RESP;
            cnt       <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          mem_req   <= 1'b0;
          mem_we    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t sbq[$];

  mem_access_unit #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every response pulse is matched against the oldest
  // expectation, including the cycle it should land in.
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        check("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check({e.tag, "_rdata"}, rsp_rdata, e.rdata);
        check({e.tag, "_err"}, {31'd0, rsp_err}, {31'd0, e.err});
        check({e.tag, "_cycle"}, cyc, e.cyc);
      end
    end
  end

  // One directed operation. ack_at = WAIT_ACK cycle (1-based) in which the
  // RAM acks, 0 = never. exp_lat = cycles from presentation to rsp_valid.
  task automatic run_op(input string tag, input logic we, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rword, input int ack_at, input int exp_lat,
                        input logic exp_err, input logic [31:0] exp_rdata,
                        input logic [31:0] exp_maddr, input logic [3:0] exp_be,
                        input logic [31:0] exp_wdata, input logic late_ack);
    int   w;
    logic got;
    exp_t e;
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    e.tag   = tag;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.cyc   = cyc + exp_lat;
    sbq.push_back(e);
    w   = 0;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(posedge clk); #1;
      if (rsp_valid) begin
        got = 1'b1;
        check({tag, "_memreq_at_rsp"}, {31'd0, mem_req}, 32'd0);
        check({tag, "_stall_at_rsp"}, {31'd0, stall}, 32'd0);
        mem_ack = late_ack;
      end else if (mem_req) begin
        w++;
        if (w == 1) begin
          check({tag, "_mem_addr"}, mem_addr, exp_maddr);
          check({tag, "_mem_be"}, {28'd0, mem_be}, {28'd0, exp_be});
          check({tag, "_mem_we"}, {31'd0, mem_we}, {31'd0, we});
          check({tag, "_stall"}, {31'd0, stall}, 32'd1);
          if (we) check({tag, "_mem_wdata"}, mem_wdata, exp_wdata);
        end
        mem_ack   = (w == ack_at);
        mem_rdata = rword;
      end else begin
        mem_ack = 1'b0;
      end
    end
    check({tag, "_rsp_seen"}, {31'd0, got}, 32'd1);
    check({tag, "_memreq_cycles"}, w, exp_lat - 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check({tag, "_ready_after"}, {31'd0, req_ready}, 32'd1);
    if (late_ack) begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      check({tag, "_late_ack_ignored"}, {31'd0, rsp_valid}, 32'd0);
      check({tag, "_late_ack_ready"}, {31'd0, req_ready}, 32'd1);
    end
  endtask

  initial begin
    // Reset for two cycles.
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // lb / lbu from the top byte lane, acked in the first WAIT_ACK cycle.
    run_op("lb", 1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'h0, 32'h80FF_1234, 1, 2,
           1'b0, 32'hFFFF_FF80, 32'h0000_1000, 4'b1000, 32'h0, 1'b0);
    run_op("lbu", 1'b0, 2'b00, 1'b1, 32'h0000_1003, 32'h0, 32'h80FF_1234, 1, 2,
           1'b0, 32'h0000_0080, 32'h0000_1000, 4'b1000, 32'h0, 1'b0);

    // sh to the upper half, acked in the third WAIT_ACK cycle.
    run_op("sh", 1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h1234_ABCD, 32'h0, 3, 4,
           1'b0, 32'h0, 32'h0000_2000, 4'b1100, 32'hABCD_ABCD, 1'b0);

    // Misaligned word and illegal size are rejected without a RAM request.
    run_op("lw_mis", 1'b0, 2'b10, 1'b0, 32'h0000_3001, 32'h0, 32'h0, 0, 1,
           1'b1, 32'h0, 32'h0, 4'b0000, 32'h0, 1'b0);
    run_op("sz11", 1'b0, 2'b11, 1'b0, 32'h0000_3000, 32'h0, 32'h0, 0, 1,
           1'b1, 32'h0, 32'h0, 4'b0000, 32'h0, 1'b0);
    run_op("lh_mis", 1'b0, 2'b01, 1'b0, 32'h0000_3003, 32'h0, 32'h0, 0, 1,
           1'b1, 32'h0, 32'h0, 4'b0000, 32'h0, 1'b0);

    // No ack: mem_req for 16 cycles, then error; a late ack is ignored.
    run_op("lw_tmo", 1'b0, 2'b10, 1'b0, 32'h0000_4000, 32'h0, 32'hFFFF_FFFF, 0, 17,
           1'b1, 32'h0, 32'h0000_4000, 4'b1111, 32'h0, 1'b1);

    // Normal traffic after the timeout.
    run_op("lh", 1'b0, 2'b01, 1'b0, 32'h0000_5002, 32'h0, 32'h8001_7FFF, 1, 2,
           1'b0, 32'hFFFF_8001, 32'h0000_5000, 4'b1100, 32'h0, 1'b0);
    run_op("lhu", 1'b0, 2'b01, 1'b1, 32'h0000_5000, 32'h0, 32'h8001_8FFF, 2, 3,
           1'b0, 32'h0000_8FFF, 32'h0000_5000, 4'b0011, 32'h0, 1'b0);
    run_op("lw", 1'b0, 2'b10, 1'b0, 32'h0000_6000, 32'h0, 32'hDEAD_BEEF, 2, 3,
           1'b0, 32'hDEAD_BEEF, 32'h0000_6000, 4'b1111, 32'h0, 1'b0);
    run_op("sb", 1'b1, 2'b00, 1'b0, 32'h0000_7001, 32'h0000_00AB, 32'h0, 1, 2,
           1'b0, 32'h0, 32'h0000_7000, 4'b0010, 32'hABAB_ABAB, 1'b0);

    // Reset in the middle of a store.
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_size  = 2'b10;
    req_addr  = 32'h0000_8000;
    req_wdata = 32'h5555_AAAA;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_rst_memreq_before", {31'd0, mem_req}, 32'd1);
    rstn = 1'b0;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_memreq", {31'd0, mem_req}, 32'd0);
    check("mid_rst_memwe", {31'd0, mem_we}, 32'd0);
    check("mid_rst_ready", {31'd0, req_ready}, 32'd1);
    check("mid_rst_rsp", {31'd0, rsp_valid}, 32'd0);
    rstn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("post_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end

    // Recovery after the mid-access reset.
    run_op("lw_after_rst", 1'b0, 2'b10, 1'b0, 32'h0000_9004, 32'h0, 32'h0123_4567, 1, 2,
           1'b0, 32'h0123_4567, 32'h0000_9004, 4'b1111, 32'h0, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    check("sb_empty", sbq.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
